// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// Double-flop synchronises the line. Every data and stop bit is sampled at mid-bit.
// A good frame emits one byte with a single-cycle valid strobe.
// A frame with a low stop bit emits a single-cycle frame_err strobe instead.
module uart_rx #(
  parameter int SYSCLK = 125_000_000,
  parameter int BPS    = 9600,
  parameter int DELAY  = SYSCLK / BPS,
  parameter int HALF   = DELAY / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  // Terminal counts for the bit timer, precomputed at full counter width.
  localparam logic [31:0] DELAY_M1 = 32'(DELAY - 1);
  localparam logic [31:0] HALF_M1  = 32'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic        rx_s1;
  logic        rx_s2;
  logic [31:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  // armed stops a line held low (break) from retriggering frame after frame.
  logic        armed;

  // Bring the asynchronous line into the clk domain. The line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Receive FSM with bit timer, bit index, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= 32'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      armed     <= 1'b0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Result strobes are single-cycle by default.
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= 32'd0;
          if (rx_s2) begin
            armed <= 1'b1;
          end
          // Accept a falling edge only after the line has been seen high.
          if (armed && !rx_s2) begin
            state <= START;
            armed <= 1'b0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= 32'd0;
            if (!rx_s2) begin
              // The start bit is still low at mid-bit, so it is genuine.
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // The line bounced back high, so this was a glitch. Drop it silently.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end

        DATA: begin
          if (baud_cnt == DELAY_M1) begin
            baud_cnt        <= 32'd0;
            shift[bit_idx]  <= rx_s2;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end

        STOP: begin
          if (baud_cnt == DELAY_M1) begin
            // Return at mid-stop-bit so a start bit that follows at once is caught.
            baud_cnt <= 32'd0;
            state    <= IDLE;
            busy     <= 1'b0;
            if (rx_s2) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= 32'd0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Uses a scaled bit period of 250 clocks so that the whole run stays short.
module tb_uart_rx;

  localparam int SYSCLK  = 25_000_000;
  localparam int BPS     = 100_000;
  localparam int DELAY   = SYSCLK / BPS;            // 250 clocks per bit
  localparam int HALF    = DELAY / 2;               // 125
  localparam int LATENCY = 3 + HALF + 9 * DELAY;    // 2378

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         cyc = 0;
  int         v_cnt = 0;
  int         e_cnt = 0;
  int         v_cyc = 0;
  int         both_cnt = 0;
  int         data_chg_cnt = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rxq[$];

  uart_rx #(
    .SYSCLK(SYSCLK),
    .BPS   (BPS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        v_cnt = v_cnt + 1;
        v_cyc = cyc;
        rxq.push_back(data);
      end
      if (frame_err) e_cnt = e_cnt + 1;
      if (valid && frame_err) both_cnt = both_cnt + 1;
      if (!valid && data !== prev_data) data_chg_cnt = data_chg_cnt + 1;
    end
    prev_data = data;
  end

  // Drive one frame. The caller is at posedge+1. Each bit is held for bit_clks edges.
  task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_bit);
    rx = 1'b0;
    repeat (bit_clks) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (bit_clks) @(posedge clk);
    #1;
  endtask

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_tests++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_idle;
    int bad;
    bad = 0;
    for (int i = 0; i < 5 * DELAY; i++) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    n_tests++;
    if (data !== 8'h00) begin n_fail++; $display("FAIL idle_data: got %h expected 00", data); end
    $display("[TB] idle 5 bit times, active cycles %0d", bad);
  endtask

  task automatic test_single;
    int v0, e0, start, lat;
    v0 = v_cnt;
    e0 = e_cnt;
    start = cyc;
    send_frame(8'hA5, DELAY, 1'b1);
    idle_clks(10);
    lat = v_cyc - start;
    n_tests++;
    if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", v_cnt - v0); end
    n_tests++;
    if (e_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", e_cnt - e0); end
    n_tests++;
    if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", data); end
    n_tests++;
    if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected %0d +-1", lat, LATENCY);
    end
    $display("[TB] single byte data=%h latency=%0d", data, lat);
  endtask

  task automatic test_back_to_back;
    int e0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h3C;
    e0 = e_cnt;
    rxq.delete();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], DELAY, 1'b1);
    idle_clks(10);
    n_tests++;
    if (rxq.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", rxq.size()); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (i >= rxq.size()) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got none expected %h", i, exp_b[i]);
      end else if (rxq[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]);
      end
    end
    n_tests++;
    if (e_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d expected 0", e_cnt - e0); end
    $display("[TB] back-to-back received %0d bytes", rxq.size());
  endtask

  task automatic test_glitch;
    int v0, e0;
    logic busy_early, busy_before;
    v0 = v_cnt;
    e0 = e_cnt;
    busy_early  = 1'b0;
    busy_before = 1'b0;
    rx = 1'b0;
    for (int i = 1; i <= HALF + 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 100) rx = 1'b1;
      if (i == 5) busy_early = busy;
      if (i == HALF + 2) busy_before = busy;
    end
    n_tests++;
    if (busy_early !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", busy_early); end
    n_tests++;
    if (busy_before !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hold: got %b expected 1", busy_before); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
    idle_clks(DELAY);
    n_tests++;
    if (v_cnt - v0 !== 0 || e_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_pulses: got valid %0d frame_err %0d expected 0 0", v_cnt - v0, e_cnt - e0);
    end
    $display("[TB] glitch 100 clocks, busy fell after %0d clocks", HALF + 3);
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = v_cnt;
    e0 = e_cnt;
    send_frame(8'h55, DELAY, 1'b0);
    idle_clks(DELAY);
    n_tests++;
    if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", e_cnt - e0); end
    n_tests++;
    if (v_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", v_cnt - v0); end
    n_tests++;
    if (data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data_hold: got %h expected 3c", data); end
    $display("[TB] framing error frame, data held %h", data);
  endtask

  task automatic test_break;
    int v0, e0;
    v0 = v_cnt;
    e0 = e_cnt;
    rx = 1'b0;
    repeat (30 * DELAY) @(posedge clk);
    #1;
    n_tests++;
    if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL break_frame_err: got %0d expected 1", e_cnt - e0); end
    n_tests++;
    if (v_cnt - v0 !== 0) begin n_fail++; $display("FAIL break_valid: got %0d expected 0", v_cnt - v0); end
    idle_clks(2 * DELAY);
    n_tests++;
    if (e_cnt - e0 !== 1 || v_cnt - v0 !== 0) begin
      n_fail++;
      $display("FAIL break_release: got frame_err %0d valid %0d expected 1 0", e_cnt - e0, v_cnt - v0);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b expected 0", busy); end
    $display("[TB] break 30 bit times, frame_err pulses %0d", e_cnt - e0);
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    logic [7:0] b;
    b = 8'h81;
    rx = 1'b0;
    repeat (DELAY) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DELAY) @(posedge clk);
      #1;
    end
    v0 = v_cnt;
    e0 = e_cnt;
    // Assert reset between edges so that only the asynchronous path can clear the outputs.
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", data); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_tests++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pulses: got valid %b frame_err %b expected 0 0", valid, frame_err);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_clks(DELAY);
    n_tests++;
    if (v_cnt - v0 !== 0 || e_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_pulse: got valid %0d frame_err %0d expected 0 0", v_cnt - v0, e_cnt - e0);
    end
    send_frame(8'h81, DELAY, 1'b1);
    idle_clks(10);
    n_tests++;
    if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_rx_count: got %0d expected 1", v_cnt - v0); end
    n_tests++;
    if (data !== 8'h81) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected 81", data); end
    $display("[TB] reset mid-frame, then received %h", data);
  endtask

  task automatic test_skew;
    int v0, e0;
    int bit_clks [2];
    bit_clks[0] = DELAY + DELAY * 4 / 100;  // 4% slow transmitter
    bit_clks[1] = DELAY - DELAY * 4 / 100;  // 4% fast transmitter
    for (int r = 0; r < 2; r++) begin
      v0 = v_cnt;
      e0 = e_cnt;
      send_frame(8'hC3, bit_clks[r], 1'b1);
      idle_clks(20);
      n_tests++;
      if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL skew%0d_valid: got %0d expected 1", r, v_cnt - v0); end
      n_tests++;
      if (data !== 8'hC3) begin n_fail++; $display("FAIL skew%0d_data: got %h expected c3", r, data); end
      n_tests++;
      if (e_cnt - e0 !== 0) begin n_fail++; $display("FAIL skew%0d_frame_err: got %0d expected 0", r, e_cnt - e0); end
      $display("[TB] skew bit=%0d clocks data=%h", bit_clks[r], data);
    end
  endtask

  task automatic test_invariants;
    n_tests++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL inv_exclusive: got %0d overlaps expected 0", both_cnt); end
    n_tests++;
    if (data_chg_cnt !== 0) begin n_fail++; $display("FAIL inv_data_with_valid: got %0d changes expected 0", data_chg_cnt); end
    $display("[TB] invariants overlaps=%0d stray data changes=%0d", both_cnt, data_chg_cnt);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid();
    test_skew();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
